decode_stage: RTL
=================

# decode_stage

Decode stage of the five-stage RV32I pipeline. Sits directly downstream of the fetch stage and consumes its IF/ID outputs: instruction, PC and PC+4. Contains the 32×32 register file (written from writeback), the main and ALU control decoders and the immediate extender. Drives the ID/EX pipeline register with flush support for hazard handling.

## Interface
Parameters:
- None. Widths are fixed at RV32I: 32-bit data, 5-bit register indices.

Ports:
- clock  in  1  Single clock. All state updates on its rising edge.
- reset  in  1  Synchronous, active-high.
- InstrD  in  32  Instruction from the IF/ID register.
- PCD  in  32  PC of InstrD.
- PCPlus4D  in  32  PCD+4.
- FlushE  in  1  Load a bubble into ID/EX on the next edge.
- RegWriteW  in  1  Writeback enable.
- RdW  in  5  Writeback destination.
- ResultW  in  32  Writeback data.
- Rs1D, Rs2D  out  5  Combinational source indices, InstrD[19:15] and [24:20], for the hazard unit.
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  Registered control.
- ResultSrcE  out  2  00 = ALU, 01 = memory, 10 = PC+4.
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  Registered data.
- Rs1E, Rs2E, RdE  out  5 each  Registered register indices.

## Operation
Decoded opcodes:
- lw 0000011
- sw 0100011
- R-type 0110011
- beq 1100011
- I-ALU 0010011
- jal 1101111
- Any other opcode decodes as a NOP: all control 0, ImmExt 0.

Immediate formats:
- I: {20×i[31], i[31:20]}
- S: {20×i[31], i[31:25], i[11:7]}
- B: {19×i[31], i[31], i[7], i[30:25], i[11:8], 0}
- J: {11×i[31], i[31], i[19:12], i[20], i[30:21], 0}

ALU decode:
- ALUOp 00 → add (lw, sw).
- ALUOp 01 → sub (beq).
- ALUOp 10 → funct3/funct7 decode:
  - funct3 000 with {op[5], funct7[5]} = 11 → sub, otherwise add.
  - 010 → slt; 110 → or; 111 → and; other funct3 → add.

Register file:
- 32 entries.
- x0 reads 0 always. Writes to x0 are discarded.
- Written on the rising edge when RegWriteW = 1.
- Reads are combinational.

ID/EX register, priority reset > FlushE > normal load:
- reset: every registered output and every register-file entry becomes 0.
- FlushE: every ID/EX output becomes 0, i.e. a bubble. The register-file write still occurs.
- Otherwise: ID/EX captures the decoded values.

## Timing
- Decode-to-E latency is 1 cycle. Values for InstrD appear on the E outputs after the next rising edge.
- Rs1D and Rs2D have zero latency.
- Reset: all outputs read 0 on the cycle after the reset edge, including RdE and ImmExtE.
- Reset mid-operation clears state in flight. A writeback presented in the same cycle as reset is dropped.
- FlushE and RegWriteW in the same cycle: the flush affects ID/EX only; the write completes.
- Simultaneous writeback and read of the same register (RdW = Rs1D or Rs2D, RdW ≠ 0) is governed by the Configuration section.

## Configuration
- DECODE_WB_BYPASS_EN defined: RD1 and RD2 return ResultW when RegWriteW = 1, RdW matches the source index and RdW ≠ 0. The same-cycle write is visible in RD1E/RD2E after the edge.
- Not defined: reads return the pre-write register content. The hazard unit must stall one cycle for this case.

## Test plan
- Reset: assert reset for 2 cycles with InstrD = 0x00700293 → every E output is 0, and a later read of any register is 0.
- addi x5,x0,7 (0x00700293) → after 1 edge:
  - RegWriteE = 1, ALUSrcE = 1, ALUControlE = 000
  - ImmExtE = 7, RdE = 5, ResultSrcE = 00
- sw x5,-4(x2) (0xFE512E23) → MemWriteE = 1, RegWriteE = 0, ImmExtE = 0xFFFFFFFC, Rs1E = 2, Rs2E = 5.
- jal x1,+8 (0x008000EF), PCD = 0x100 → JumpE = 1, ResultSrcE = 10, ImmExtE = 8, PCE = 0x100, PCPlus4E = 0x104.
- RegWriteW = 1, RdW = 5, ResultW = 0x1234, with InstrD = add x6,x5,x5 (0x00528333) in the same cycle:
  - With the macro: RD1E = RD2E = 0x1234.
  - Without the macro: the prior value.
  - In both builds, x5 reads 0x1234 on the next decode.
- Write RdW = 0, ResultW = 0xDEAD → a subsequent read of x0 gives 0.
- beq with FlushE = 1 → BranchE = 0 and all E outputs 0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: main/ALU decoders, immediate extender, 32x32 register file and ID/EX register.
// Optional feature macro: DECODE_WB_BYPASS_EN (same-cycle writeback forwarded onto RD1/RD2).
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        FlushE,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE
);

    typedef enum logic [6:0] {
        OP_LW   = 7'b0000011,
        OP_SW   = 7'b0100011,
        OP_R    = 7'b0110011,
        OP_BEQ  = 7'b1100011,
        OP_IALU = 7'b0010011,
        OP_JAL  = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_src_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    logic        w_reg_write;
    logic        w_mem_write;
    logic        w_jump;
    logic        w_branch;
    logic        w_alu_src;
    logic [1:0]  w_result_src;
    logic [1:0]  w_alu_op;
    imm_src_e    w_imm_src;
    alu_ctrl_e   w_alu_ctrl;
    logic [31:0] w_imm_ext;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    logic [31:0] r_regs [32];

    logic        r_reg_write;
    logic        r_mem_write;
    logic        r_jump;
    logic        r_branch;
    logic        r_alu_src;
    logic [1:0]  r_result_src;
    logic [2:0]  r_alu_ctrl;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [31:0] r_imm_ext;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;

    assign Rs1D = InstrD[19:15];
    assign Rs2D = InstrD[24:20];

    always_comb begin
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_jump       = 1'b0;
        w_branch     = 1'b0;
        w_alu_src    = 1'b0;
        w_result_src = 2'b00;
        w_alu_op     = 2'b00;
        w_imm_src    = IMM_NONE;
        case (InstrD[6:0])
            OP_LW: begin
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_result_src = 2'b01;
                w_imm_src    = IMM_I;
            end
            OP_SW: begin
                w_mem_write = 1'b1;
                w_alu_src   = 1'b1;
                w_imm_src   = IMM_S;
            end
            OP_R: begin
                w_reg_write = 1'b1;
                w_alu_op    = 2'b10;
            end
            OP_BEQ: begin
                w_branch  = 1'b1;
                w_alu_op  = 2'b01;
                w_imm_src = IMM_B;
            end
            OP_IALU: begin
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
                w_alu_op    = 2'b10;
                w_imm_src   = IMM_I;
            end
            OP_JAL: begin
                w_reg_write  = 1'b1;
                w_jump       = 1'b1;
                w_result_src = 2'b10;
                w_imm_src    = IMM_J;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_imm_ext = '0;
        case (w_imm_src)
            IMM_I:   w_imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
            IMM_S:   w_imm_ext = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B:   w_imm_ext = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
            IMM_J:   w_imm_ext = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
            default: w_imm_ext = '0;
        endcase
    end

    // Only R-type (op[5]=1) can select sub via funct7; addi with imm[10]=1 stays add.
    always_comb begin
        w_alu_ctrl = ALU_ADD;
        case (w_alu_op)
            2'b01: w_alu_ctrl = ALU_SUB;
            2'b10: begin
                case (InstrD[14:12])
                    3'b000:  w_alu_ctrl = (InstrD[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
                    3'b010:  w_alu_ctrl = ALU_SLT;
                    3'b110:  w_alu_ctrl = ALU_OR;
                    3'b111:  w_alu_ctrl = ALU_AND;
                    default: w_alu_ctrl = ALU_ADD;
                endcase
            end
            default: w_alu_ctrl = ALU_ADD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (RegWriteW && (RdW != 5'd0)) begin
            r_regs[RdW] <= ResultW;
        end
    end

`ifdef DECODE_WB_BYPASS_EN
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (Rs1D != 5'd0) begin
            w_rd1 = (RegWriteW && (RdW == Rs1D)) ? ResultW : r_regs[Rs1D];
        end
        if (Rs2D != 5'd0) begin
            w_rd2 = (RegWriteW && (RdW == Rs2D)) ? ResultW : r_regs[Rs2D];
        end
    end
`else
    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (Rs1D != 5'd0) begin
            w_rd1 = r_regs[Rs1D];
        end
        if (Rs2D != 5'd0) begin
            w_rd2 = r_regs[Rs2D];
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset || FlushE) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_jump       <= 1'b0;
            r_branch     <= 1'b0;
            r_alu_src    <= 1'b0;
            r_result_src <= '0;
            r_alu_ctrl   <= '0;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_imm_ext    <= '0;
            r_pc         <= '0;
            r_pc_plus4   <= '0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_rd         <= '0;
        end else begin
            r_reg_write  <= w_reg_write;
            r_mem_write  <= w_mem_write;
            r_jump       <= w_jump;
            r_branch     <= w_branch;
            r_alu_src    <= w_alu_src;
            r_result_src <= w_result_src;
            r_alu_ctrl   <= w_alu_ctrl;
            r_rd1        <= w_rd1;
            r_rd2        <= w_rd2;
            r_imm_ext    <= w_imm_ext;
            r_pc         <= PCD;
            r_pc_plus4   <= PCPlus4D;
            r_rs1        <= InstrD[19:15];
            r_rs2        <= InstrD[24:20];
            r_rd         <= InstrD[11:7];
        end
    end

    assign RegWriteE   = r_reg_write;
    assign MemWriteE   = r_mem_write;
    assign JumpE       = r_jump;
    assign BranchE     = r_branch;
    assign ALUSrcE     = r_alu_src;
    assign ResultSrcE  = r_result_src;
    assign ALUControlE = r_alu_ctrl;
    assign RD1E        = r_rd1;
    assign RD2E        = r_rd2;
    assign ImmExtE     = r_imm_ext;
    assign PCE         = r_pc;
    assign PCPlus4E    = r_pc_plus4;
    assign Rs1E        = r_rs1;
    assign Rs2E        = r_rs2;
    assign RdE         = r_rd;

endmodule
